// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------------------------
// uart_rx_fifo
//
// Oversampling UART receiver feeding a first-word-fall-through receive FIFO.
// The serial line is synchronised, framed by a small FSM driven by a free-running
// CLK-domain bit timer, and every good byte is queued for the downstream consumer.
//
// Optional feature macro: UART_RX_PARITY_EN
//   undefined : 8N1 frames, no parity logic.
//   defined   : 8E1 frames; a parity mismatch discards the byte and pulses FERR.
//
// Parameters
//   CLK_DIV  CLK cycles per bit (>= 4); the start bit is sampled at CLK_DIV/2.
//   FIFO_AW  FIFO address width; depth is 2**FIFO_AW.
//
// Ports
//   CLK     in   sole clock, rising edge.
//   RST_N   in   asynchronous active-low reset.
//   RXD     in   asynchronous serial line, idle high.
//   DOUT    out  head-of-FIFO byte, meaningful while DVALID is high.
//   DVALID  out  FIFO not empty.
//   DREADY  in   consumer takes DOUT when DVALID & DREADY.
//   FERR    out  one-cycle pulse: bad stop bit (or parity mismatch).
//   OVF     out  one-cycle pulse: good byte dropped because the FIFO was full.
//   LEVEL   out  FIFO occupancy, 0 .. 2**FIFO_AW.
// ---------------------------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int unsigned CLK_DIV = 434,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               RXD,
  output logic [7:0]         DOUT,
  output logic               DVALID,
  input  logic               DREADY,
  output logic               FERR,
  output logic               OVF,
  output logic [FIFO_AW:0]   LEVEL
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam int unsigned TimerW = $clog2(CLK_DIV);
  localparam logic [TimerW-1:0] HalfLoad = TimerW'(CLK_DIV / 2 - 1);
  localparam logic [TimerW-1:0] BitLoad = TimerW'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] FullLevel = (FIFO_AW + 1)'(Depth);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_e;

  // ------------------------------------------------------------------------------------------
  // Input synchroniser (resets to the idle-high line level)
  // ------------------------------------------------------------------------------------------
  logic rx_meta_q;
  logic rxs_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= RXD;
      rxs_q     <= rx_meta_q;
    end
  end

  // ------------------------------------------------------------------------------------------
  // Receive FSM
  // ------------------------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              tick;
  logic              push;
  logic              ferr_set;
`ifdef UART_RX_PARITY_EN
  logic              par_err_q, par_err_d;
`endif

  assign tick = (timer_q == '0);

  always_comb begin
    state_d   = state_q;
    // Timer free-runs down to zero and parks there; states reload it when needed.
    timer_d   = tick ? timer_q : timer_q - TimerW'(1);
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif

    case (state_q)
      StIdle: begin
        if (!rxs_q) begin
          state_d = StStart;
          timer_d = HalfLoad;
        end
      end

      StStart: begin
        if (tick) begin
          if (rxs_q) begin
            // Line went back high before mid start bit: treat as a glitch.
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_idx_d = 3'd0;
            timer_d   = BitLoad;
`ifdef UART_RX_PARITY_EN
            par_err_d = 1'b0;
`endif
          end
        end
      end

      StData: begin
        if (tick) begin
          shreg_d[bit_idx_q] = rxs_q;
          timer_d            = BitLoad;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tick) begin
          // Even parity: the parity bit equals the XOR of the data bits.
          par_err_d = rxs_q ^ (^shreg_q);
          timer_d   = BitLoad;
          state_d   = StStop;
        end
      end
`endif

      StStop: begin
        // Sampling mid stop bit and returning to idle leaves half a bit of
        // margin to catch a zero-gap next start bit.
        if (tick) begin
          if (rxs_q) begin
`ifdef UART_RX_PARITY_EN
            if (par_err_q) begin
              ferr_set = 1'b1;
            end else begin
              push = 1'b1;
            end
`else
            push = 1'b1;
`endif
            state_d = StIdle;
          end else begin
            ferr_set = 1'b1;
            state_d  = StBreak;
          end
        end
      end

      StBreak: begin
        // A long low line reports one framing error, then waits for idle.
        if (rxs_q) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end
`endif

  // ------------------------------------------------------------------------------------------
  // Receive FIFO (first-word fall-through)
  // ------------------------------------------------------------------------------------------
  logic [7:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               full;
  logic               pop;
  logic               do_push;
  logic               ovf_set;
  logic               ferr_q, ovf_q;

  assign full    = (count_q == FullLevel);
  assign pop     = DVALID & DREADY;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= 8'h00;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= shreg_q;
        wptr_q        <= wptr_q + FIFO_AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + FIFO_AW'(1);
      end
      case ({do_push, pop})
        2'b10:   count_q <= count_q + (FIFO_AW + 1)'(1);
        2'b01:   count_q <= count_q - (FIFO_AW + 1)'(1);
        default: count_q <= count_q;
      endcase
      ferr_q <= ferr_set;
      ovf_q  <= ovf_set;
    end
  end

  assign DOUT   = mem_q[rptr_q];
  assign DVALID = (count_q != '0);
  assign LEVEL  = count_q;
  assign FERR   = ferr_q;
  assign OVF    = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------------------------
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (CLK_DIV=16, depth 8).
// Build with +define+UART_RX_PARITY_EN to exercise the parity configuration.
// ---------------------------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int unsigned Div = 16;
  localparam int unsigned Aw  = 3;

  logic          CLK;
  logic          RST_N;
  logic          RXD;
  logic [7:0]    DOUT;
  logic          DVALID;
  logic          DREADY;
  logic          FERR;
  logic          OVF;
  logic [Aw:0]   LEVEL;

  int checks = 0;
  int passed = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;

  uart_rx_fifo #(
    .CLK_DIV (Div),
    .FIFO_AW (Aw)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .RXD    (RXD),
    .DOUT   (DOUT),
    .DVALID (DVALID),
    .DREADY (DREADY),
    .FERR   (FERR),
    .OVF    (OVF),
    .LEVEL  (LEVEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pulse counters: every high cycle counts, so a stretched pulse shows up as extra counts.
  always @(negedge CLK) begin
    if (FERR === 1'b1) ferr_cnt++;
    if (OVF === 1'b1) ovf_cnt++;
  end

  // All stimulus is applied 1 time unit after a rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    RXD = b;
    cycles(Div);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bad);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_bad);
`else
    if (par_bad) $display("note: parity not enabled, par_bad ignored");
`endif
    send_bit(stop_bit);
    RXD = 1'b1;
  endtask

  task automatic pop_one;
    DREADY = 1'b1;
    cycles(1);
    DREADY = 1'b0;
  endtask

  task automatic test_reset;
    int f0;
    int o0;
    RST_N  = 1'b0;
    RXD    = 1'b1;
    DREADY = 1'b0;
    cycles(3);
    checks++; if (DVALID !== 1'b0) $display("FAIL reset_dvalid got %b want 0", DVALID);
    else passed++;
    checks++; if (LEVEL !== 4'd0) $display("FAIL reset_level got %0d want 0", LEVEL);
    else passed++;
    checks++; if (FERR !== 1'b0) $display("FAIL reset_ferr got %b want 0", FERR);
    else passed++;
    checks++; if (OVF !== 1'b0) $display("FAIL reset_ovf got %b want 0", OVF);
    else passed++;
    RST_N = 1'b1;
    f0 = ferr_cnt;
    o0 = ovf_cnt;
    cycles(20 * Div);
    checks++; if (LEVEL !== 4'd0) $display("FAIL idle_level got %0d want 0", LEVEL);
    else passed++;
    checks++; if (ferr_cnt !== f0) $display("FAIL idle_ferr got %0d want %0d", ferr_cnt, f0);
    else passed++;
    checks++; if (ovf_cnt !== o0) $display("FAIL idle_ovf got %0d want %0d", ovf_cnt, o0);
    else passed++;
  endtask

  task automatic test_basic;
    send_frame(8'hA5, 1'b1, 1'b0);
    cycles(2);
    checks++; if (DVALID !== 1'b1) $display("FAIL a5_dvalid got %b want 1", DVALID);
    else passed++;
    checks++; if (DOUT !== 8'hA5) $display("FAIL a5_dout got %h want a5", DOUT);
    else passed++;
    checks++; if (LEVEL !== 4'd1) $display("FAIL a5_level got %0d want 1", LEVEL);
    else passed++;
    pop_one();
    checks++; if (LEVEL !== 4'd0) $display("FAIL a5_pop_level got %0d want 0", LEVEL);
    else passed++;
    checks++; if (DVALID !== 1'b0) $display("FAIL a5_pop_dvalid got %b want 0", DVALID);
    else passed++;
  endtask

  task automatic test_glitch;
    int f0;
    f0 = ferr_cnt;
    RXD = 1'b0;
    cycles(4);
    RXD = 1'b1;
    cycles(3 * Div);
    checks++; if (LEVEL !== 4'd0) $display("FAIL glitch_level got %0d want 0", LEVEL);
    else passed++;
    checks++; if (ferr_cnt !== f0) $display("FAIL glitch_ferr got %0d want %0d", ferr_cnt, f0);
    else passed++;
  endtask

  task automatic test_framing;
    int f0;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    RXD = 1'b0;
    cycles(3 * Div);
    RXD = 1'b1;
    cycles(2 * Div);
    checks++; if (ferr_cnt !== f0 + 1) $display("FAIL ferr_count got %0d want %0d", ferr_cnt, f0 + 1);
    else passed++;
    checks++; if (LEVEL !== 4'd0) $display("FAIL ferr_level got %0d want 0", LEVEL);
    else passed++;
    send_frame(8'h11, 1'b1, 1'b0);
    cycles(2);
    checks++; if (DOUT !== 8'h11) $display("FAIL after_ferr_dout got %h want 11", DOUT);
    else passed++;
    checks++; if (LEVEL !== 4'd1) $display("FAIL after_ferr_level got %0d want 1", LEVEL);
    else passed++;
    pop_one();
  endtask

  task automatic test_back_to_back;
    int o0;
    int f0;
    logic [7:0] exp;
    o0 = ovf_cnt;
    f0 = ferr_cnt;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b0);
    cycles(2);
    checks++; if (LEVEL !== 4'd8) $display("FAIL full_level got %0d want 8", LEVEL);
    else passed++;
    checks++; if (ovf_cnt !== o0 + 1) $display("FAIL ovf_count got %0d want %0d", ovf_cnt, o0 + 1);
    else passed++;
    checks++; if (ferr_cnt !== f0) $display("FAIL b2b_ferr got %0d want %0d", ferr_cnt, f0);
    else passed++;
    for (int i = 1; i <= 8; i++) begin
      exp = 8'(i);
      checks++; if (DOUT !== exp) $display("FAIL drain_dout[%0d] got %h want %h", i, DOUT, exp);
      else passed++;
      pop_one();
    end
    checks++; if (DVALID !== 1'b0) $display("FAIL drained_dvalid got %b want 0", DVALID);
    else passed++;
    // Refill across the pointer wrap.
    for (int i = 0; i < 3; i++) send_frame(8'h21 + 8'(i), 1'b1, 1'b0);
    cycles(2);
    checks++; if (LEVEL !== 4'd3) $display("FAIL refill_level got %0d want 3", LEVEL);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      exp = 8'h21 + 8'(i);
      checks++; if (DOUT !== exp) $display("FAIL refill_dout[%0d] got %h want %h", i, DOUT, exp);
      else passed++;
      pop_one();
    end
    checks++; if (LEVEL !== 4'd0) $display("FAIL refill_empty got %0d want 0", LEVEL);
    else passed++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int f0;
    f0 = ferr_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    cycles(2);
    checks++; if (ferr_cnt !== f0 + 1) $display("FAIL par_ferr got %0d want %0d", ferr_cnt, f0 + 1);
    else passed++;
    checks++; if (LEVEL !== 4'd0) $display("FAIL par_level got %0d want 0", LEVEL);
    else passed++;
    send_frame(8'h07, 1'b1, 1'b0);
    cycles(2);
    checks++; if (DOUT !== 8'h07) $display("FAIL par_ok_dout got %h want 07", DOUT);
    else passed++;
    checks++; if (ferr_cnt !== f0 + 1) $display("FAIL par_ok_ferr got %0d want %0d", ferr_cnt, f0 + 1);
    else passed++;
    pop_one();
  endtask
`endif

  task automatic test_async_reset;
    int f0;
    send_frame(8'h5A, 1'b1, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    f0 = ferr_cnt;
    #2;
    RST_N = 1'b0;
    #1;
    checks++; if (LEVEL !== 4'd0) $display("FAIL arst_level got %0d want 0", LEVEL);
    else passed++;
    checks++; if (DVALID !== 1'b0) $display("FAIL arst_dvalid got %b want 0", DVALID);
    else passed++;
    RXD = 1'b1;
    cycles(2);
    RST_N = 1'b1;
    cycles(12 * Div);
    checks++; if (ferr_cnt !== f0) $display("FAIL arst_ferr got %0d want %0d", ferr_cnt, f0);
    else passed++;
    checks++; if (LEVEL !== 4'd0) $display("FAIL arst_idle_level got %0d want 0", LEVEL);
    else passed++;
    send_frame(8'h77, 1'b1, 1'b0);
    cycles(2);
    checks++; if (DOUT !== 8'h77) $display("FAIL arst_next_dout got %h want 77", DOUT);
    else passed++;
    pop_one();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Oversampling UART receiver with an on-chip receive FIFO. It sits directly upstream of the host-side byte consumer: it turns the raw `RXD` line into validated 8N1 bytes and queues them. Bytes leave through a first-word-fall-through valid/ready port. It replaces ad-hoc start-bit-synchronised bit clocks with a free-running `CLK`-domain bit timer.

## Interface
Parameters:
- `CLK_DIV`, 434 — `CLK` cycles per bit (≥ 4); half-bit point = `CLK_DIV/2` (integer floor).
- `FIFO_AW`, 3 — FIFO address width; depth = 2^`FIFO_AW` (default 8 entries).

Ports:
- `CLK` in 1 — sole clock; all logic on rising edge.
- `RST_N` in 1 — reset, asynchronous and active-low.
- `RXD` in 1 — asynchronous serial line, idle high.
- `DOUT` out 8 — head-of-FIFO byte; valid only while `DVALID`=1.
- `DVALID` out 1 — FIFO not empty.
- `DREADY` in 1 — consumer accepts `DOUT` when `DVALID` & `DREADY`.
- `FERR` out 1 — one-cycle pulse: framing error (or parity error when enabled).
- `OVF` out 1 — one-cycle pulse: good byte dropped because FIFO full.
- `LEVEL` out `FIFO_AW+1` — current FIFO occupancy, 0..2^`FIFO_AW`.

## Operation
- Reset: synchroniser flops = 1; state IDLE; bit timer = 0; FIFO pointers = 0; `DVALID`=0, `FERR`=0, `OVF`=0, `LEVEL`=0; `DOUT` = don't-care (register is cleared to 0).
- `RXD` passes through a 2-flop synchroniser; FSM uses synchronised `rxs` only.
- FSM states: IDLE, START, DATA, [PARITY], STOP, BREAK.
  - IDLE: `rxs`=0 → START, timer loads `CLK_DIV/2 - 1`.
  - START: at timer expiry (timer==0) sample `rxs`. 1 → IDLE (glitch rejected). 0 → DATA, bit index 0, timer `CLK_DIV-1`.
  - DATA: at each expiry shift `rxs` into bit [index] (LSB first), reload timer. After bit 7 → PARITY if enabled, else STOP.
  - STOP: at expiry sample `rxs`. 1 and no parity error → push byte, then IDLE. 0 → `FERR` pulse, byte discarded, BREAK.
  - BREAK: wait for `rxs`=1, then IDLE. Long low lines yield exactly one `FERR`.
- FIFO push when full and no simultaneous pop: byte dropped, `OVF` pulse, contents unchanged.
- Push and pop in the same cycle: both occur. When full, the pop frees the slot and no `OVF` is raised. When empty, no pop is possible (`DVALID`=0), so only the push occurs.
- Pointers are `FIFO_AW` bits and wrap modulo depth. `LEVEL` is +1 on push-only, -1 on pop-only, and unchanged on both.
- `DREADY` while `DVALID`=0 is ignored.

## Timing
- `RXD` fall to START entry: 2–3 `CLK`.
- Sample points: start bit at `CLK_DIV/2` after detect, then every `CLK_DIV` cycles.
- Stop-bit sample cycle → `DVALID`/`LEVEL` update on the next rising edge (1-cycle latency). `FERR`/`OVF` are asserted in that same next cycle, for exactly 1 cycle.
- Pop: `DOUT` shows the next entry, and `LEVEL` drops, the cycle after the handshake.
- Back-to-back frames: the receiver is back in IDLE half a bit before the nominal stop-bit end, so a zero-gap next start bit is caught.
- Async `RST_N` assertion mid-frame or mid-FIFO: all state clears immediately. The partial byte and queued bytes are lost. No pulse is emitted.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - adds a PARITY state after bit 7, sampling one even-parity bit at the usual interval, then → STOP;
  - a mismatch is latched; at STOP the byte is discarded and `FERR` pulses even if the stop bit is 1;
  - the frame is 8E1.
- Undefined: no PARITY state, 8N1, no parity logic synthesised.

## Test plan
- Reset then idle line → `DVALID`=0, `LEVEL`=0, no `FERR`/`OVF` for 20 bit times.
- With `CLK_DIV`=16, send 0xA5, `DREADY`=0 → `DVALID`=1, `DOUT`=0xA5, `LEVEL`=1. Assert `DREADY` one cycle → `LEVEL`=0, `DVALID`=0.
- Low glitch of 4 `CLK` on `RXD` → no byte, no `FERR`, FSM back in IDLE.
- Send 0x3C with stop bit forced 0, then line held low 3 bit times → single `FERR` pulse, `LEVEL` unchanged. Next valid 0x11 is received correctly.
- Send 9 bytes 0x01..0x09 back-to-back, `DREADY`=0, depth 8 → `LEVEL`=8, one `OVF` on 0x09. Draining returns 0x01..0x08 in order, and pointers wrap on the next fill.
- With `UART_RX_PARITY_EN`, send 0x07 with odd parity bit → `FERR` pulse, no push. Correct parity → `DOUT`=0x07.
